// File: rtl/bcd_time_field.sv
// Two-digit BCD time field with run/set modes, range-checked load and blinking
// decimal points; the carry output chains fields (seconds -> minutes -> hours).
module bcd_time_field #(
  parameter int unsigned MODULUS     = 60,
  parameter int unsigned BLINK_TICKS = 25_000_000,
  parameter int unsigned BLINK_W     = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       set_mode,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       ones_dp,
  output logic       tens_dp,
  output logic       carry_out,
  output logic       load_err
);

  localparam int unsigned TERM      = MODULUS - 1;
  localparam int unsigned TERM_TENS = TERM / 10;
  localparam int unsigned TERM_ONES = TERM % 10;
  localparam int unsigned VAL_W     = 8;

  typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [3:0]           ones_d, tens_d;
  logic                 dp_q, dp_d;
  logic                 carry_d, err_d;
  logic [BLINK_W-1:0]   blink_q, blink_d;
  logic [VAL_W-1:0]     load_val;
  logic                 load_ok, at_term, at_zero, step_up, step_down;

  assign load_val = VAL_W'(load_tens) * VAL_W'(10) + VAL_W'(load_ones);
  assign load_ok  = (load_ones <= 4'd9) && (load_tens <= 4'd9) && (load_val <= VAL_W'(TERM));
  assign at_term  = (tens == 4'(TERM_TENS)) && (ones == 4'(TERM_ONES));
  assign at_zero  = (tens == 4'd0) && (ones == 4'd0);

  // Mode state: the registered state decides how this cycle's inputs are used.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (set_mode)  state_d = SET;
      SET:     if (!set_mode) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Digit update: load wins, then tick (RUN) or inc/dec (SET).
  always_comb begin
    ones_d    = ones;
    tens_d    = tens;
    carry_d   = 1'b0;
    err_d     = 1'b0;
    step_up   = 1'b0;
    step_down = 1'b0;
    if (load) begin
      if (load_ok) begin
        ones_d = load_ones;
        tens_d = load_tens;
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      step_up = tick;
      carry_d = tick && at_term;
    end else begin
      step_up   = inc && !dec;
      step_down = dec && !inc;
    end

    if (step_up) begin
      if (at_term) begin
        ones_d = 4'd0;
        tens_d = 4'd0;
      end else if (ones == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens + 4'd1;
      end else begin
        ones_d = ones + 4'd1;
      end
    end else if (step_down) begin
      if (at_zero) begin
        ones_d = 4'(TERM_ONES);
        tens_d = 4'(TERM_TENS);
      end else if (ones == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens - 4'd1;
      end else begin
        ones_d = ones - 4'd1;
      end
    end
  end

  // Blink timing: restart lit on SET entry, toggle every BLINK_TICKS cycles.
  always_comb begin
    blink_d = blink_q;
    dp_d    = dp_q;
    if (state_d == RUN) begin
      blink_d = '0;
      dp_d    = 1'b0;
    end else if (state_q == RUN) begin
      blink_d = '0;
      dp_d    = 1'b1;
    end else if (blink_q == BLINK_W'(BLINK_TICKS - 1)) begin
      blink_d = '0;
      dp_d    = !dp_q;
    end else begin
      blink_d = blink_q + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      ones      <= 4'd0;
      tens      <= 4'd0;
      dp_q      <= 1'b0;
      blink_q   <= '0;
      carry_out <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones      <= ones_d;
      tens      <= tens_d;
      dp_q      <= dp_d;
      blink_q   <= blink_d;
      carry_out <= carry_d;
      load_err  <= err_d;
    end
  end

  assign ones_dp = dp_q;
  assign tens_dp = dp_q;

endmodule

// File: tb/tb_bcd_time_field.sv
// Bench for bcd_time_field: a 60-field and a 24-field share stimulus and are
// compared every cycle against an arithmetic reference model.
module tb_bcd_time_field;

  localparam int unsigned BT = 4;
  localparam int MODS [2] = '{60, 24};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, set_mode, inc, dec, load;
  logic [3:0] load_tens, load_ones;
  logic [3:0] ones_o [2];
  logic [3:0] tens_o [2];
  logic       odp_o [2];
  logic       tdp_o [2];
  logic       carry_o [2];
  logic       err_o [2];

  int n_checks = 0;
  int n_err    = 0;

  int mv [2];
  bit mset [2];
  int mk [2];
  bit mdp [2];
  bit mcarry [2];
  bit merr [2];

  always #5 clk = ~clk;

  bcd_time_field #(.MODULUS(60), .BLINK_TICKS(BT), .BLINK_W(3)) dut60 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .set_mode(set_mode), .inc(inc),
    .dec(dec), .load(load), .load_tens(load_tens), .load_ones(load_ones),
    .ones(ones_o[0]), .tens(tens_o[0]), .ones_dp(odp_o[0]), .tens_dp(tdp_o[0]),
    .carry_out(carry_o[0]), .load_err(err_o[0]));

  bcd_time_field #(.MODULUS(24), .BLINK_TICKS(BT), .BLINK_W(3)) dut24 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .set_mode(set_mode), .inc(inc),
    .dec(dec), .load(load), .load_tens(load_tens), .load_ones(load_ones),
    .ones(ones_o[1]), .tens(tens_o[1]), .ones_dp(odp_o[1]), .tens_dp(tdp_o[1]),
    .carry_out(carry_o[1]), .load_err(err_o[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; mset[i] = 1'b0; mk[i] = 0;
      mdp[i] = 1'b0; mcarry[i] = 1'b0; merr[i] = 1'b0;
    end
  endtask

  // Reference: value as an integer, dp phase from cycles spent in SET.
  task automatic model_step();
    int lv;
    for (int i = 0; i < 2; i++) begin
      mcarry[i] = 1'b0;
      merr[i]   = 1'b0;
      if (load) begin
        lv = 10 * int'(load_tens) + int'(load_ones);
        if (load_ones <= 9 && load_tens <= 9 && lv <= MODS[i] - 1) mv[i] = lv;
        else merr[i] = 1'b1;
      end else if (!mset[i]) begin
        if (tick) begin
          mv[i] = (mv[i] + 1) % MODS[i];
          mcarry[i] = (mv[i] == 0);
        end
      end else if (inc && !dec) begin
        mv[i] = (mv[i] + 1) % MODS[i];
      end else if (dec && !inc) begin
        mv[i] = (mv[i] + MODS[i] - 1) % MODS[i];
      end
      if (set_mode && !mset[i]) mk[i] = 0;
      else if (set_mode) mk[i] = mk[i] + 1;
      mdp[i]  = set_mode && ((mk[i] / BT) % 2 == 0);
      mset[i] = set_mode;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("m%0d ones", MODS[i]), 32'(ones_o[i]), 32'(mv[i] % 10));
      check($sformatf("m%0d tens", MODS[i]), 32'(tens_o[i]), 32'(mv[i] / 10));
      check($sformatf("m%0d ones_dp", MODS[i]), 32'(odp_o[i]), 32'(mdp[i]));
      check($sformatf("m%0d tens_dp", MODS[i]), 32'(tdp_o[i]), 32'(mdp[i]));
      check($sformatf("m%0d carry_out", MODS[i]), 32'(carry_o[i]), 32'(mcarry[i]));
      check($sformatf("m%0d load_err", MODS[i]), 32'(err_o[i]), 32'(merr[i]));
    end
  endtask

  // Drive at the falling edge, model at the rising edge, sample 1 time unit later.
  task automatic step(input bit t, input bit s, input bit i, input bit d,
                      input bit l, input logic [3:0] lt, input logic [3:0] lo);
    tick = t; set_mode = s; inc = i; dec = d; load = l;
    load_tens = lt; load_ones = lo;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    tick = 0; set_mode = 0; inc = 0; dec = 0; load = 0;
    load_tens = 0; load_ones = 0;
    model_reset();
    #3;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Full wrap of the 60 field (the 24 field wraps twice along the way).
    for (int n = 0; n < 60; n++) step(1, 0, 0, 0, 0, 4'd0, 4'd0);

    // Hours terminal: 23 -> 00 with carry; 24 rejected by the 24 field only.
    step(0, 0, 0, 0, 1, 4'd2, 4'd3);
    step(1, 0, 0, 0, 0, 4'd0, 4'd0);
    step(0, 0, 0, 0, 1, 4'd2, 4'd4);
    step(0, 0, 0, 0, 1, 4'd0, 4'd0);

    // SET mode editing, then blink window and exit.
    step(0, 1, 0, 0, 0, 4'd0, 4'd0);
    step(0, 1, 0, 1, 0, 4'd0, 4'd0);
    step(0, 1, 1, 0, 0, 4'd0, 4'd0);
    step(0, 1, 1, 1, 0, 4'd0, 4'd0);
    step(1, 1, 0, 0, 0, 4'd0, 4'd0);
    for (int n = 0; n < 9; n++) step(0, 1, 0, 0, 0, 4'd0, 4'd0);
    step(0, 0, 0, 0, 0, 4'd0, 4'd0);
    step(0, 0, 0, 0, 0, 4'd0, 4'd0);

    // Load beats tick at the terminal value; out-of-range loads rejected.
    step(0, 0, 0, 0, 1, 4'd5, 4'd9);
    step(1, 0, 0, 0, 1, 4'd1, 4'd2);
    step(0, 0, 0, 0, 1, 4'd6, 4'd0);
    step(0, 0, 0, 0, 1, 4'd0, 4'd10);

    // Asynchronous reset between edges while in SET at 37.
    step(0, 0, 0, 0, 1, 4'd3, 4'd7);
    step(0, 1, 0, 0, 0, 4'd0, 4'd0);
    step(0, 1, 0, 0, 0, 4'd0, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    set_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 4'd0, 4'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit sm;
      sm = set_mode;
      if ($urandom_range(15) == 0) sm = !sm;
      step(1'($urandom_range(1)), sm, 1'($urandom_range(3) == 0),
           1'($urandom_range(3) == 0), 1'($urandom_range(9) == 0),
           4'($urandom_range(($urandom_range(3) == 0) ? 15 : 9)),
           4'($urandom_range(($urandom_range(3) == 0) ? 15 : 9)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
